pcie_rx_credit: RTL and testbench

PCIE_RX_CREDIT -- requirements
Module: pcie_rx_credit

---
 rtl/pcie_rx_credit.sv | 161 ++++++++++++++++
 tb/tb_pcie_rx_credit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_credit.sv
// Receive-side PCIe flow-control credit return: parses TLP headers from a 16-bit
// word stream and pulses posted / non-posted credit returns one cycle after each TLP ends.
module pcie_rx_credit #(
  parameter int         CNT_W  = 16,
  parameter logic [7:0] PD_MAX = 8'd255
) (
  input  logic             pcie_clk,
  input  logic             sys_rst_n,
  input  logic             rx_st,
  input  logic             rx_end,
  input  logic [15:0]      rx_data,
  output logic             ph_cr,
  output logic             pd_cr,
  output logic             nph_cr,
  output logic             npd_cr,
  output logic [7:0]       pd_num,
  output logic [CNT_W-1:0] cnt_ph,
  output logic [CNT_W-1:0] cnt_pd,
  output logic [CNT_W-1:0] cnt_nph,
  output logic [CNT_W-1:0] cnt_npd,
  output logic             err_short,
  output logic             err_len
);

  typedef enum logic [1:0] {IDLE, HDR1, BODY, RET} state_t;

  state_t      state, state_nxt;
  logic        has_data;
  logic [4:0]  tlp_type;
  logic [9:0]  tlp_len;
  logic        latch_hdr, latch_len, ret_go, short_evt;
  logic [9:0]  len_eff;
  logic        is_posted, is_nonposted;
  logic [10:0] pd_raw;
  logic [7:0]  pd_val;
  logic        pd_ovf;
  logic [1:0]  unused_bits;

  assign unused_bits = {rx_data[15], rx_data[13]};

  // Data credits are ceil(LenDW/4); a Length field of zero encodes 1024 DW.
  function automatic logic [10:0] pd_credits(input logic [9:0] length);
    logic [10:0] len_dw;
    len_dw = (length == 10'd0) ? 11'd1024 : {1'b0, length};
    return (len_dw + 11'd3) >> 2;
  endfunction

  function automatic logic [7:0] pd_saturate(input logic [10:0] credits);
    return (credits > {3'b000, PD_MAX}) ? PD_MAX : credits[7:0];
  endfunction

  always_comb begin
    state_nxt = state;
    latch_hdr = 1'b0;
    latch_len = 1'b0;
    ret_go    = 1'b0;
    short_evt = 1'b0;
    case (state)
      IDLE: begin
        if (rx_st && rx_end) begin
          short_evt = 1'b1;
        end else if (rx_st) begin
          latch_hdr = 1'b1;
          state_nxt = HDR1;
        end
      end
      HDR1: begin
        if (rx_st && rx_end) begin
          short_evt = 1'b1;
          state_nxt = IDLE;
        end else if (rx_st) begin
          short_evt = 1'b1;
          latch_hdr = 1'b1;
          state_nxt = HDR1;
        end else begin
          latch_len = 1'b1;
          if (rx_end) begin
            ret_go    = 1'b1;
            state_nxt = RET;
          end else begin
            state_nxt = BODY;
          end
        end
      end
      BODY: begin
        if (rx_st && rx_end) begin
          short_evt = 1'b1;
          state_nxt = IDLE;
        end else if (rx_st) begin
          short_evt = 1'b1;
          latch_hdr = 1'b1;
          state_nxt = HDR1;
        end else if (rx_end) begin
          ret_go    = 1'b1;
          state_nxt = RET;
        end
      end
      RET: begin
        // A new TLP may start in the return cycle without an idle gap.
        state_nxt = IDLE;
        if (rx_st && rx_end) begin
          short_evt = 1'b1;
        end else if (rx_st) begin
          latch_hdr = 1'b1;
          state_nxt = HDR1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A TLP ending on its second word supplies Length in the same cycle as rx_end.
  assign len_eff      = latch_len ? rx_data[9:0] : tlp_len;
  assign is_posted    = ((tlp_type == 5'b00000) && has_data) || (tlp_type[4:3] == 2'b10);
  assign is_nonposted = ((tlp_type == 5'b00000 || tlp_type == 5'b00001) && !has_data) ||
                        (tlp_type == 5'b00010) || (tlp_type[4:1] == 4'b0010);
  assign pd_raw       = pd_credits(len_eff);
  assign pd_val       = pd_saturate(pd_raw);
  assign pd_ovf       = pd_raw > {3'b000, PD_MAX};

  always_ff @(posedge pcie_clk) begin
    if (latch_hdr) begin
      has_data <= rx_data[14];
      tlp_type <= rx_data[12:8];
    end
    if (latch_len) tlp_len <= rx_data[9:0];
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      ph_cr     <= 1'b0;
      pd_cr     <= 1'b0;
      nph_cr    <= 1'b0;
      npd_cr    <= 1'b0;
      pd_num    <= 8'd0;
      cnt_ph    <= '0;
      cnt_pd    <= '0;
      cnt_nph   <= '0;
      cnt_npd   <= '0;
      err_short <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ph_cr  <= ret_go && is_posted;
      pd_cr  <= ret_go && is_posted && has_data;
      nph_cr <= ret_go && is_nonposted;
      npd_cr <= ret_go && is_nonposted && has_data;
      if (ret_go && is_posted) cnt_ph <= cnt_ph + CNT_W'(1);
      if (ret_go && is_posted && has_data) begin
        pd_num <= pd_val;
        cnt_pd <= cnt_pd + CNT_W'(pd_val);
        if (pd_ovf) err_len <= 1'b1;
      end
      if (ret_go && is_nonposted) cnt_nph <= cnt_nph + CNT_W'(1);
      if (ret_go && is_nonposted && has_data) cnt_npd <= cnt_npd + CNT_W'(1);
      if (short_evt) err_short <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_rx_credit.sv
// Bench for pcie_rx_credit: directed vector table, hand-written corner sequences,
// and random traffic checked against a TLP-level reference model.
module tb_pcie_rx_credit;

  localparam int CNT_W = 16;

  logic             pcie_clk = 1'b0;
  logic             sys_rst_n;
  logic             rx_st, rx_end;
  logic [15:0]      rx_data;
  logic             ph_cr, pd_cr, nph_cr, npd_cr;
  logic [7:0]       pd_num;
  logic [CNT_W-1:0] cnt_ph, cnt_pd, cnt_nph, cnt_npd;
  logic             err_short, err_len;

  pcie_rx_credit #(.CNT_W(CNT_W), .PD_MAX(8'd255)) dut (
    .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .rx_st(rx_st), .rx_end(rx_end),
    .rx_data(rx_data), .ph_cr(ph_cr), .pd_cr(pd_cr), .nph_cr(nph_cr), .npd_cr(npd_cr),
    .pd_num(pd_num), .cnt_ph(cnt_ph), .cnt_pd(cnt_pd), .cnt_nph(cnt_nph),
    .cnt_npd(cnt_npd), .err_short(err_short), .err_len(err_len)
  );

  always #5 pcie_clk = ~pcie_clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: collects the words of the TLP in flight and classifies at its end.
  bit               m_in;
  logic [15:0]      m_words[$];
  logic             m_ph, m_pd, m_nph, m_npd, m_es, m_el;
  logic [7:0]       m_pdn;
  logic [CNT_W-1:0] m_cph, m_cpd, m_cnph, m_cnpd;

  task automatic model_reset();
    m_in = 0; m_words.delete();
    m_ph = 0; m_pd = 0; m_nph = 0; m_npd = 0; m_es = 0; m_el = 0;
    m_pdn = 0; m_cph = 0; m_cpd = 0; m_cnph = 0; m_cnpd = 0;
  endtask

  task automatic model_credit();
    bit   data;
    int   typ, len, dw, cr;
    bit   posted, nonp;
    data   = m_words[0][14];
    typ    = int'(m_words[0][12:8]);
    len    = int'(m_words[1][9:0]);
    posted = (typ == 0 && data) || (typ >= 16 && typ <= 23);
    nonp   = (!data && (typ == 0 || typ == 1)) || typ == 2 || typ == 4 || typ == 5;
    if (posted) begin
      m_ph = 1; m_cph = m_cph + 1;
      if (data) begin
        dw = (len == 0) ? 1024 : len;
        cr = (dw + 3) / 4;
        if (cr > 255) begin cr = 255; m_el = 1; end
        m_pd = 1; m_pdn = 8'(cr); m_cpd = m_cpd + CNT_W'(cr);
      end
    end
    if (nonp) begin
      m_nph = 1; m_cnph = m_cnph + 1;
      if (data) begin m_npd = 1; m_cnpd = m_cnpd + 1; end
    end
  endtask

  task automatic model_step(input bit st, input bit en, input logic [15:0] d);
    m_ph = 0; m_pd = 0; m_nph = 0; m_npd = 0;
    if (st && en) begin
      m_es = 1; m_in = 0; m_words.delete();
    end else if (st) begin
      if (m_in) m_es = 1;
      m_words.delete(); m_words.push_back(d); m_in = 1;
    end else if (m_in) begin
      if (m_words.size() == 1) m_words.push_back(d);
      if (en) begin model_credit(); m_in = 0; end
    end
  endtask

  function automatic logic [77:0] dut_bundle();
    return {ph_cr, pd_cr, nph_cr, npd_cr, pd_num, cnt_ph, cnt_pd, cnt_nph, cnt_npd,
            err_short, err_len};
  endfunction

  function automatic logic [77:0] model_bundle();
    return {m_ph, m_pd, m_nph, m_npd, m_pdn, m_cph, m_cpd, m_cnph, m_cnpd, m_es, m_el};
  endfunction

  task automatic check(input string name, input logic [77:0] got, input logic [77:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit en, input logic [15:0] d);
    rx_st = st; rx_end = en; rx_data = d;
    @(posedge pcie_clk);
    model_step(st, en, d);
    #1;
    check("model", dut_bundle(), model_bundle());
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0; rx_st = 0; rx_end = 0; rx_data = 0;
    model_reset();
    @(posedge pcie_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    bit          st;
    bit          en;
    logic [15:0] d;
    logic [3:0]  cr;   // {ph, pd, nph, npd} expected after this word's edge
    logic [7:0]  pdn;
  } vec_t;

  vec_t vecs[$];

  localparam logic [7:0] HDR_OPTS [16] = '{8'h00, 8'h40, 8'h20, 8'h60, 8'h04, 8'h44, 8'h05,
    8'h45, 8'h02, 8'h42, 8'h30, 8'h70, 8'h0A, 8'h4A, 8'h01, 8'h1F};

  initial begin
    vecs.push_back('{1, 0, 16'h0000, 4'b0000, 8'd3});   // MRd 3DW
    vecs.push_back('{0, 0, 16'h0001, 4'b0000, 8'd3});
    vecs.push_back('{0, 0, 16'h1234, 4'b0000, 8'd3});
    vecs.push_back('{0, 0, 16'h0000, 4'b0000, 8'd3});
    vecs.push_back('{0, 1, 16'h5678, 4'b0010, 8'd3});
    vecs.push_back('{1, 0, 16'h4400, 4'b0000, 8'd3});   // CfgWr0 started in RET
    vecs.push_back('{0, 0, 16'h0001, 4'b0000, 8'd3});
    vecs.push_back('{0, 0, 16'h0000, 4'b0000, 8'd3});
    vecs.push_back('{0, 1, 16'hABCD, 4'b0011, 8'd3});
    vecs.push_back('{1, 0, 16'h4A00, 4'b0000, 8'd3});   // CplD: no credit
    vecs.push_back('{0, 0, 16'h0004, 4'b0000, 8'd3});
    vecs.push_back('{0, 0, 16'h0000, 4'b0000, 8'd3});
    vecs.push_back('{0, 1, 16'h0000, 4'b0000, 8'd3});
    vecs.push_back('{0, 0, 16'h0000, 4'b0000, 8'd3});
    vecs.push_back('{1, 0, 16'h4000, 4'b0000, 8'd3});   // MWr Length 17
    vecs.push_back('{0, 0, 16'h0011, 4'b0000, 8'd3});
    vecs.push_back('{0, 1, 16'hFFFF, 4'b1100, 8'd5});
    vecs.push_back('{1, 0, 16'h3000, 4'b0000, 8'd5});   // Msg without data
    vecs.push_back('{0, 1, 16'h0000, 4'b1000, 8'd5});
    vecs.push_back('{0, 1, 16'h0000, 4'b0000, 8'd5});   // stray rx_end ignored
    vecs.push_back('{1, 0, 16'h4200, 4'b0000, 8'd5});   // IOWr
    vecs.push_back('{0, 0, 16'h0001, 4'b0000, 8'd5});
    vecs.push_back('{0, 1, 16'h0000, 4'b0011, 8'd5});

    sys_rst_n = 1'b0; rx_st = 0; rx_end = 0; rx_data = 0;
    model_reset();
    repeat (2) @(posedge pcie_clk);
    #1;
    check("reset_state", dut_bundle(), 78'd0);
    sys_rst_n = 1'b1;

    // MWr, Length 9, fourteen words
    step(1, 0, 16'h4000);
    step(0, 0, 16'h0009);
    for (int i = 0; i < 11; i++) step(0, 0, 16'($urandom));
    step(0, 1, 16'h0000);
    check("mwr_pulses", {ph_cr, pd_cr, nph_cr, npd_cr}, 4'b1100);
    check("mwr_pd_num", pd_num, 8'd3);
    check("mwr_cnt_ph", cnt_ph, 1);
    check("mwr_cnt_pd", cnt_pd, 3);
    step(0, 0, 16'h0000);
    check("mwr_pulse_width", {ph_cr, pd_cr}, 2'b00);

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].en, vecs[i].d);
      check($sformatf("vec%0d", i), {ph_cr, pd_cr, nph_cr, npd_cr, pd_num},
            {vecs[i].cr, vecs[i].pdn});
    end

    // Length 0 saturates
    step(1, 0, 16'h4000);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    check("len0_pd_cr", pd_cr, 1);
    check("len0_pd_num", pd_num, 8'd255);
    check("len0_err_len", err_len, 1);

    // rx_st with rx_end in the same word
    apply_reset();
    step(1, 1, 16'h4000);
    check("short_same_err", err_short, 1);
    check("short_same_cr", {ph_cr, pd_cr, nph_cr, npd_cr}, 4'b0000);
    step(0, 0, 16'h0000);
    check("short_same_cr2", {ph_cr, pd_cr, nph_cr, npd_cr}, 4'b0000);

    // Second rx_st while in BODY abandons the first TLP
    apply_reset();
    step(1, 0, 16'h4000);
    step(0, 0, 16'h0004);
    step(0, 0, 16'h0000);
    step(1, 0, 16'h0000);
    check("short_body_err", err_short, 1);
    check("short_body_cr", {ph_cr, pd_cr, nph_cr, npd_cr}, 4'b0000);
    step(0, 0, 16'h0001);
    step(0, 1, 16'h0000);
    check("short_body_next", {ph_cr, pd_cr, nph_cr, npd_cr, cnt_ph}, {4'b0010, 16'd0});

    // Reset while in BODY
    step(1, 0, 16'h4000);
    step(0, 0, 16'h0005);
    step(0, 0, 16'h0000);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_bundle(), 78'd0);
    @(posedge pcie_clk); #1;
    sys_rst_n = 1'b1;
    step(0, 1, 16'h0000);
    check("reset_discard", {ph_cr, pd_cr, nph_cr, npd_cr}, 4'b0000);
    step(1, 0, 16'h4000);
    step(0, 0, 16'h0005);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    check("post_reset_mwr", {ph_cr, pd_cr, pd_num, cnt_ph, cnt_pd},
          {2'b11, 8'd2, 16'd1, 16'd2});

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit st, en;
      logic [15:0] d;
      st = ($urandom % 6) == 0;
      en = ($urandom % 5) == 0;
      d  = 16'($urandom);
      if (st) d[15:8] = HDR_OPTS[$urandom % 16];
      else if (($urandom % 32) == 0) d[9:0] = 10'd0;
      if (i % 1000 == 999) apply_reset();
      step(st, en, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
